// File: rtl/alarm_controller.sv
// Alarm decision logic: holds the programmed alarm time, compares it with the
// timekeeper, and sequences ringing, snooze and stop into the tone enable.
module alarm_controller #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
    parameter int unsigned DEF_HH      = 7,
    parameter int unsigned DEF_MM      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic [4:0] cur_hh,
    input  logic [5:0] cur_mm,
    input  logic [5:0] cur_ss,
    input  logic       alarm_en,
    input  logic       set_alarm,
    input  logic [4:0] alarm_hh_in,
    input  logic [5:0] alarm_mm_in,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       Alarm,
    output logic [1:0] state,
    output logic [2:0] snooze_cnt,
    output logic [4:0] alarm_hh,
    output logic [5:0] alarm_mm
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3} state_t;

    localparam logic [7:0] RING_LAST   = 8'(RING_SECS - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
    localparam logic [2:0] MAX_SNZ     = 3'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic       alarm_q, alarm_d;
    logic [2:0] snooze_cnt_q, snooze_cnt_d;
    logic [4:0] alarm_hh_q, alarm_hh_d;
    logic [5:0] alarm_mm_q, alarm_mm_d;
    logic [7:0] ring_secs_q, ring_secs_d;
    logic [9:0] snz_secs_q, snz_secs_d;

    logic [1:0] stop_sync_q, stop_sync_d;
    logic [1:0] snz_sync_q, snz_sync_d;
    logic       stop_prev_q, stop_prev_d, stop_pulse_q, stop_pulse_d;
    logic       snz_prev_q, snz_prev_d, snz_pulse_q, snz_pulse_d;

    logic time_match, set_valid;

    // Buttons are asynchronous: two sync stages, then a registered rising-edge pulse.
    always_comb begin
        stop_sync_d  = {stop_sync_q[0], stop_btn};
        snz_sync_d   = {snz_sync_q[0], snooze_btn};
        stop_prev_d  = stop_sync_q[1];
        snz_prev_d   = snz_sync_q[1];
        stop_pulse_d = stop_sync_q[1] & ~stop_prev_q;
        snz_pulse_d  = snz_sync_q[1] & ~snz_prev_q;
    end

    assign time_match = sec_tick && (cur_hh == alarm_hh_q) && (cur_mm == alarm_mm_q)
                        && (cur_ss == 6'd0);
    assign set_valid  = set_alarm && (alarm_hh_in <= 5'd23) && (alarm_mm_in <= 6'd59);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        snooze_cnt_d = snooze_cnt_q;
        alarm_hh_d   = alarm_hh_q;
        alarm_mm_d   = alarm_mm_q;
        ring_secs_d  = ring_secs_q;
        snz_secs_d   = snz_secs_q;

        if (!alarm_en) begin
            state_d      = IDLE;
            snooze_cnt_d = 3'd0;
            ring_secs_d  = 8'd0;
            snz_secs_d   = 10'd0;
        end else if (set_valid) begin
            alarm_hh_d   = alarm_hh_in;
            alarm_mm_d   = alarm_mm_in;
            state_d      = ARMED;
            snooze_cnt_d = 3'd0;
            ring_secs_d  = 8'd0;
            snz_secs_d   = 10'd0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (time_match) begin
                        state_d     = RINGING;
                        ring_secs_d = 8'd0;
                    end
                end
                RINGING: begin
                    if (stop_pulse_q) begin
                        state_d      = ARMED;
                        snooze_cnt_d = 3'd0;
                        ring_secs_d  = 8'd0;
                    end else if (snz_pulse_q && (snooze_cnt_q < MAX_SNZ)) begin
                        state_d      = SNOOZE;
                        snooze_cnt_d = snooze_cnt_q + 3'd1;
                        snz_secs_d   = 10'd0;
                    end else if (sec_tick) begin
                        if (ring_secs_q == RING_LAST) begin
                            state_d      = ARMED;
                            snooze_cnt_d = 3'd0;
                            ring_secs_d  = 8'd0;
                        end else begin
                            ring_secs_d = ring_secs_q + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_pulse_q) begin
                        state_d      = ARMED;
                        snooze_cnt_d = 3'd0;
                        snz_secs_d   = 10'd0;
                    end else if (sec_tick) begin
                        if (snz_secs_q == SNOOZE_LAST) begin
                            state_d     = RINGING;
                            ring_secs_d = 8'd0;
                            snz_secs_d  = 10'd0;
                        end else begin
                            snz_secs_d = snz_secs_q + 10'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Registered from the next state so Alarm tracks state with no input-to-output path.
        alarm_d = (state_d == RINGING);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            alarm_q      <= 1'b0;
            snooze_cnt_q <= 3'd0;
            alarm_hh_q   <= 5'(DEF_HH);
            alarm_mm_q   <= 6'(DEF_MM);
            ring_secs_q  <= 8'd0;
            snz_secs_q   <= 10'd0;
            stop_sync_q  <= 2'b00;
            snz_sync_q   <= 2'b00;
            stop_prev_q  <= 1'b0;
            snz_prev_q   <= 1'b0;
            stop_pulse_q <= 1'b0;
            snz_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alarm_q      <= alarm_d;
            snooze_cnt_q <= snooze_cnt_d;
            alarm_hh_q   <= alarm_hh_d;
            alarm_mm_q   <= alarm_mm_d;
            ring_secs_q  <= ring_secs_d;
            snz_secs_q   <= snz_secs_d;
            stop_sync_q  <= stop_sync_d;
            snz_sync_q   <= snz_sync_d;
            stop_prev_q  <= stop_prev_d;
            snz_prev_q   <= snz_prev_d;
            stop_pulse_q <= stop_pulse_d;
            snz_pulse_q  <= snz_pulse_d;
        end
    end

    assign Alarm      = alarm_q;
    assign state      = state_q;
    assign snooze_cnt = snooze_cnt_q;
    assign alarm_hh   = alarm_hh_q;
    assign alarm_mm   = alarm_mm_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with short ring/snooze periods so every
// transition is reachable in a few ticks.
module tb_alarm_controller;

    logic       clk, rst_n, sec_tick, alarm_en, set_alarm, stop_btn, snooze_btn;
    logic [4:0] cur_hh, alarm_hh_in;
    logic [5:0] cur_mm, cur_ss, alarm_mm_in;
    logic       alarm;
    logic [1:0] state;
    logic [2:0] snooze_cnt;
    logic [4:0] alarm_hh;
    logic [5:0] alarm_mm;

    int n_checks = 0;
    int n_passed = 0;

    alarm_controller #(
        .RING_SECS(5), .SNOOZE_SECS(3), .MAX_SNOOZE(2), .DEF_HH(7), .DEF_MM(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick),
        .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
        .alarm_en(alarm_en), .set_alarm(set_alarm),
        .alarm_hh_in(alarm_hh_in), .alarm_mm_in(alarm_mm_in),
        .stop_btn(stop_btn), .snooze_btn(snooze_btn),
        .Alarm(alarm), .state(state), .snooze_cnt(snooze_cnt),
        .alarm_hh(alarm_hh), .alarm_mm(alarm_mm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int hh, input int mm, input int ss);
        cur_hh   = 5'(hh);
        cur_mm   = 6'(mm);
        cur_ss   = 6'(ss);
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic load(input int hh, input int mm);
        alarm_hh_in = 5'(hh);
        alarm_mm_in = 6'(mm);
        set_alarm   = 1'b1;
        step();
        set_alarm   = 1'b0;
    endtask

    task automatic check_out(input string tag, input int st, input int al, input int cnt);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".alarm"}, int'(alarm), al);
        check({tag, ".snooze_cnt"}, int'(snooze_cnt), cnt);
    endtask

    initial begin
        rst_n = 1'b0; sec_tick = 1'b0; alarm_en = 1'b0; set_alarm = 1'b0;
        stop_btn = 1'b0; snooze_btn = 1'b0;
        cur_hh = '0; cur_mm = '0; cur_ss = '0; alarm_hh_in = '0; alarm_mm_in = '0;
        #23;
        check_out("reset", 0, 0, 0);
        check("reset.hh", int'(alarm_hh), 7);
        check("reset.mm", int'(alarm_mm), 0);
        rst_n = 1'b1;
        step();

        // Arm, trigger on the 07:00:00 tick, time out after five more ticks.
        alarm_en = 1'b1;
        step();
        check_out("armed", 1, 0, 0);
        tick(6, 59, 59);
        check_out("pre_match", 1, 0, 0);
        tick(7, 0, 0);
        check_out("trigger", 2, 1, 0);
        for (int s = 1; s <= 4; s++) tick(7, 0, s);
        check_out("ring_4", 2, 1, 0);
        tick(7, 0, 5);
        check_out("timeout", 1, 0, 0);
        for (int s = 6; s <= 59; s++) tick(7, 0, s);
        check_out("no_retrigger", 1, 0, 0);

        // Snooze cycle: press latency, snooze period, snooze limit.
        tick(7, 0, 0);
        check_out("ring2", 2, 1, 0);
        snooze_btn = 1'b1;
        step(3);
        check_out("snz_lat", 2, 1, 0);
        step();
        check_out("snz1", 3, 0, 1);
        snooze_btn = 1'b0;
        step(3);
        tick(7, 1, 0);
        tick(7, 1, 1);
        check_out("snz1_wait", 3, 0, 1);
        tick(7, 1, 2);
        check_out("snz1_end", 2, 1, 1);
        snooze_btn = 1'b1;
        step(4);
        check_out("snz2", 3, 0, 2);
        snooze_btn = 1'b0;
        step(3);
        for (int s = 0; s < 3; s++) tick(7, 2, s);
        check_out("snz2_end", 2, 1, 2);
        snooze_btn = 1'b1;
        step(4);
        check_out("snz3_ignored", 2, 1, 2);
        snooze_btn = 1'b0;
        step(3);
        for (int s = 0; s < 4; s++) tick(7, 3, s);
        check_out("ring_after_ign", 2, 1, 2);
        tick(7, 3, 4);
        check_out("timeout2", 1, 0, 0);

        // Stop and snooze together: stop wins. Held stop gives one pulse only.
        tick(7, 0, 0);
        check_out("ring3", 2, 1, 0);
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        step(4);
        check_out("stop_snz", 1, 0, 0);
        snooze_btn = 1'b0;
        tick(7, 0, 0);
        check_out("ring4", 2, 1, 0);
        step(100);
        check_out("held_stop", 2, 1, 0);
        stop_btn = 1'b0;
        step(3);
        check_out("stop_release", 2, 1, 0);

        // set_alarm during SNOOZE re-arms; out-of-range loads are ignored.
        snooze_btn = 1'b1;
        step(4);
        check_out("snz_before_set", 3, 0, 1);
        snooze_btn = 1'b0;
        load(12, 30);
        check_out("set_in_snz", 1, 0, 0);
        check("set.hh", int'(alarm_hh), 12);
        check("set.mm", int'(alarm_mm), 30);
        load(25, 10);
        check("bad_hh.hh", int'(alarm_hh), 12);
        check("bad_hh.mm", int'(alarm_mm), 30);
        load(12, 60);
        check("bad_mm.mm", int'(alarm_mm), 30);
        load(23, 59);
        check("edge.hh", int'(alarm_hh), 23);
        check("edge.mm", int'(alarm_mm), 59);

        // alarm_en low forces IDLE; no ringing while disabled.
        tick(23, 59, 0);
        check_out("ring5", 2, 1, 0);
        alarm_en = 1'b0;
        step();
        check_out("disable", 0, 0, 0);
        tick(23, 59, 0);
        check_out("disabled_match", 0, 0, 0);

        // Asynchronous reset mid-RINGING takes effect without a clock edge.
        alarm_en = 1'b1;
        step();
        tick(23, 59, 0);
        check_out("ring6", 2, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 0);
        check("async_rst.hh", int'(alarm_hh), 7);
        check("async_rst.mm", int'(alarm_mm), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Decides when the alarm sounds and drives the `Alarm` enable consumed directly by the audio tone generator (`play_sound`). `Alarm` goes to its `Alarm`/`AUD_SD` input.
- Holds the programmed alarm time and compares it against the running time-of-day from the timekeeper.
- Manages ring timeout, snooze and stop from user buttons.
- Sits between the timekeeper/button front end and the tone stage.

Parameters:
- RING_SECS, 60, seconds of ringing before automatic stop (1..255)
- SNOOZE_SECS, 300, seconds of silence per snooze (1..1023)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)
- DEF_HH, 7, alarm hour after reset (0..23)
- DEF_MM, 0, alarm minute after reset (0..59)

Ports:
- clk  in  1  system clock (same clock as tone generator)
- rst_n  in  1  asynchronous active-low reset
- sec_tick  in  1  one-cycle pulse, once per second, from timekeeper
- cur_hh  in  5  current hour, binary 0..23
- cur_mm  in  6  current minute, binary 0..59
- cur_ss  in  6  current second, binary 0..59
- alarm_en  in  1  level; alarm function enabled
- set_alarm  in  1  one-cycle pulse; load alarm_hh_in/alarm_mm_in
- alarm_hh_in  in  5  new alarm hour
- alarm_mm_in  in  6  new alarm minute
- stop_btn  in  1  debounced level, asynchronous to clk
- snooze_btn  in  1  debounced level, asynchronous to clk
- Alarm  out  1  registered tone enable to play_sound
- state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
- snooze_cnt  out  3  snoozes used in current alarm event
- alarm_hh  out  5  programmed alarm hour
- alarm_mm  out  6  programmed alarm minute

Behaviour:
- Reset (rst_n low, async): state=IDLE, Alarm=0, snooze_cnt=0, alarm_hh=DEF_HH, alarm_mm=DEF_MM, ring/snooze second counters=0, button sync/edge flops=0.
- Buttons: two-flop synchroniser, then rising-edge detect. A press high at edge n gives an internal pulse at edge n+2. The state/Alarm change is visible after edge n+3. A held button gives one pulse only.
- set_alarm: loads alarm_hh/alarm_mm on the next edge in any state. Out-of-range inputs (hh>23, mm>59) are ignored and the registers are unchanged. If state is RINGING or SNOOZE, go to ARMED, Alarm=0, snooze_cnt=0.
- alarm_en=0: from any state go to IDLE on the next edge, Alarm=0, counters cleared. This has priority over everything except reset.
- IDLE -> ARMED when alarm_en=1.
- ARMED -> RINGING on a cycle with sec_tick=1, cur_hh==alarm_hh, cur_mm==alarm_mm and cur_ss==0. Compare uses cur_* values present in the tick cycle. Entry: Alarm=1 registered on the same edge, ring counter=0. The ss==0 condition prevents retrigger within the matched minute.
- RINGING:
  - Ring counter increments on each sec_tick.
  - When the counter reaches RING_SECS: go to ARMED, Alarm=0, snooze_cnt=0.
  - Stop pulse: go to ARMED, Alarm=0, snooze_cnt=0.
  - Snooze pulse with snooze_cnt<MAX_SNOOZE: go to SNOOZE, Alarm=0, snooze_cnt+1, snooze counter=0.
  - Snooze pulse with snooze_cnt==MAX_SNOOZE: ignored; ringing continues and the ring counter is unchanged.
- SNOOZE:
  - Snooze counter increments on each sec_tick.
  - When it reaches SNOOZE_SECS: go to RINGING, Alarm=1, ring counter=0.
  - Stop pulse: go to ARMED, snooze_cnt=0.
  - Snooze pulse: ignored.
- Simultaneous events, priority: reset > alarm_en=0 > set_alarm > stop > snooze > timeout/tick.
- Counter width: counters are sized to hold their parameter and never wrap; they are compared for equality then cleared.
- Alarm is only ever 1 in RINGING. Alarm equals (state==RINGING) every cycle; there is no combinational path from inputs to Alarm.

Test Plan:
- Reset defaults: rst_n low mid-RINGING -> Alarm=0, state=0, alarm_hh=7, alarm_mm=0, snooze_cnt=0 immediately, without a clock edge.
- Trigger and timeout: RING_SECS=5, alarm_en=1, time steps 06:59:59 -> 07:00:00 with tick -> Alarm=1 after that edge, state=2. After 5 further ticks -> Alarm=0, state=1. Ticks through 07:00:01..07:00:59 -> no retrigger.
- Snooze cycle: SNOOZE_SECS=3, MAX_SNOOZE=2. Snooze press while ringing -> Alarm=0 at press edge+3, state=3, snooze_cnt=1. 3 ticks later -> Alarm=1, state=2. Second snooze -> snooze_cnt=2. Third snooze -> ignored, Alarm stays 1.
- Stop/snooze same cycle while RINGING -> state=1, Alarm=0, snooze_cnt=0. Held stop for 100 cycles -> exactly one transition.
- set_alarm 12:30 during SNOOZE -> alarm_hh=12, alarm_mm=30, state=1. set_alarm 25:10 -> registers unchanged.
- alarm_en dropped while RINGING -> state=0, Alarm=0 next edge. Match time with alarm_en=0 -> no ring.
